glitch_launch_ctrl: RTL and testbench



---
 rtl/glitch_pkg.sv | 14 +
 rtl/glitch_qualifier.sv | 34 +++
 rtl/glitch_launch_ctrl.sv | 145 ++++++++++++++
 tb/tb_glitch_launch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types and defaults for the carry-chain glitch launch/capture controller.
package glitch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWarmup = 2'd1,
        StArmed  = 2'd2
    } glitch_state_e;

    localparam int unsigned DefCmpDly       = 2;
    localparam int unsigned DefWarmupCycles = 16;
    localparam int unsigned RunW            = 8;

endpackage

// File: rtl/glitch_qualifier.sv
// Consecutive-mismatch run counter: fires once when a run reaches ALARM_THRESH,
// rearms on the first clean cycle.
module glitch_qualifier
    import glitch_pkg::*;
#(
    parameter int unsigned ALARM_THRESH = 2
) (
    input  logic clk_ps,
    input  logic resetn,
    input  logic mismatch,
    output logic fire
);

    logic [RunW-1:0] run_q, run_d;

    // Saturation keeps a long run from wrapping back through the threshold.
    always_comb begin
        run_d = '0;
        fire  = 1'b0;
        if (mismatch) begin
            run_d = (run_q == '1) ? run_q : run_q + 1'b1;
            fire  = (run_q == RunW'(ALARM_THRESH - 1));
        end
    end

    always_ff @(posedge clk_ps or negedge resetn) begin
        if (!resetn) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/glitch_launch_ctrl.sv
// Launch/compare FSM and single-entry event slot for the glitch detector.
// Define GLITCH_TIMESTAMP_EN to build the free-running timestamp for event_ts.
module glitch_launch_ctrl
    import glitch_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = DefWarmupCycles,
    parameter int unsigned ALARM_THRESH  = 2,
    parameter int unsigned CMP_DLY       = DefCmpDly,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_ps,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    output logic             tdl_in,
    input  logic             alarm,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [CNT_W-1:0] event_count,
    output logic [CNT_W-1:0] event_ts,
    output logic             glitch_flag,
    output logic             overflow,
    output logic             armed
);

    localparam int unsigned WuW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    glitch_state_e      state_q, state_d;
    logic [WuW-1:0]     wu_q, wu_d;
    logic               tdl_q, tdl_d;
    logic [CMP_DLY-1:0] hist_q, hist_d;
    logic [CMP_DLY:0]   hist_shift;
    logic               alarm_q;
    logic               mismatch, fire, accept, slot_load;
    logic               valid_q, valid_d, flag_q, flag_d, ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        state_d = state_q;
        wu_d    = wu_q;
        case (state_q)
            StIdle: begin
                wu_d = '0;
                if (enable) state_d = StWarmup;
            end
            StWarmup: begin
                if (wu_q == WuW'(WARMUP_CYCLES - 1)) state_d = StArmed;
                else                                 wu_d    = wu_q + 1'b1;
            end
            StArmed: ;
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d = StIdle;
            wu_d    = '0;
        end
    end

    // Launch starts at 1 on the first WARMUP cycle and toggles from there.
    always_comb begin
        hist_shift = {hist_q, tdl_q};
        if (state_d == StIdle)      tdl_d = 1'b0;
        else if (state_q == StIdle) tdl_d = 1'b1;
        else                        tdl_d = ~tdl_q;
        hist_d = (state_q == StIdle) ? '0 : hist_shift[CMP_DLY-1:0];
    end

    assign mismatch = (state_q == StArmed) && ((~alarm_q) != hist_q[CMP_DLY-1]);

    glitch_qualifier #(
        .ALARM_THRESH (ALARM_THRESH)
    ) u_qualifier (
        .clk_ps   (clk_ps),
        .resetn   (resetn),
        .mismatch (mismatch),
        .fire     (fire)
    );

    assign accept    = valid_q & event_ready;
    assign slot_load = fire & (~valid_q | accept);

    // A fire in the same cycle as clear takes effect on top of the cleared values.
    always_comb begin
        count_d = clear ? '0   : count_q;
        flag_d  = clear ? 1'b0 : flag_q;
        ovf_d   = clear ? 1'b0 : ovf_q;
        valid_d = valid_q & ~accept;
        if (fire) begin
            if (count_d != '1) count_d = count_d + 1'b1;
            flag_d = 1'b1;
            if (slot_load) valid_d = 1'b1;
            else           ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_ps or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            wu_q    <= '0;
            tdl_q   <= 1'b0;
            hist_q  <= '0;
            alarm_q <= 1'b0;
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wu_q    <= wu_d;
            tdl_q   <= tdl_d;
            hist_q  <= hist_d;
            alarm_q <= alarm;
            valid_q <= valid_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

`ifdef GLITCH_TIMESTAMP_EN
    logic [CNT_W-1:0] ts_cnt_q, ts_q;

    always_ff @(posedge clk_ps or negedge resetn) begin
        if (!resetn) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (slot_load) ts_q <= ts_cnt_q;
        end
    end

    assign event_ts = ts_q;
`else
    assign event_ts = '0;
`endif

    assign tdl_in      = tdl_q;
    assign event_valid = valid_q;
    assign event_count = count_q;
    assign glitch_flag = flag_q;
    assign overflow    = ovf_q;
    assign armed       = (state_q == StArmed);

endmodule

// File: tb/tb_glitch_launch_ctrl.sv
// Randomised bench for glitch_launch_ctrl: cycle-level reference model plus an
// event scoreboard checked on every handshake transfer.
module tb_glitch_launch_ctrl;

    localparam int unsigned WARMUP = 16;
    localparam int unsigned THRESH = 2;
    localparam int unsigned CMPD   = 2;
    localparam int unsigned CW     = 16;

    logic          clk_ps = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          event_ready = 1'b0;
    logic          corrupt = 1'b0;
    logic          det_ff = 1'b0;
    logic          tdl_in, alarm, event_valid, glitch_flag, overflow, armed;
    logic [CW-1:0] event_count, event_ts;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];

    glitch_launch_ctrl #(
        .WARMUP_CYCLES (WARMUP),
        .ALARM_THRESH  (THRESH),
        .CMP_DLY       (CMPD),
        .CNT_W         (CW)
    ) dut (
        .clk_ps      (clk_ps),
        .resetn      (resetn),
        .enable      (enable),
        .clear       (clear),
        .tdl_in      (tdl_in),
        .alarm       (alarm),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_count (event_count),
        .event_ts    (event_ts),
        .glitch_flag (glitch_flag),
        .overflow    (overflow),
        .armed       (armed)
    );

    always #5 clk_ps = ~clk_ps;

    // Ideal detector: alarm is the inverted launch one cycle late; corrupt flips it.
    always @(posedge clk_ps) det_ff <= tdl_in;
    assign alarm = ~det_ff ^ corrupt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_ps);
        #1;
    endtask

    task automatic glitch(input int n);
        corrupt = 1'b1;
        repeat (n) tick();
        corrupt = 1'b0;
        repeat (8) tick();
    endtask

    // Reference model. k_en counts consecutive enabled edges, so the block is in
    // WARMUP for k_en = 1..WARMUP and ARMED beyond; a corrupted alarm in cycle c-1
    // is a mismatch in cycle c.
    int k_en = 0;
    int run = 0;
    int m_count = 0;
    bit m_valid = 0, m_flag = 0, m_ovf = 0, corrupt_prev = 0;
    bit mism, fire_m, acc;
`ifdef GLITCH_TIMESTAMP_EN
    int m_tsc = 0;
`endif

    always @(negedge clk_ps) begin
        if (!resetn) begin
            k_en = 0; run = 0; m_count = 0;
            m_valid = 0; m_flag = 0; m_ovf = 0; corrupt_prev = 0;
`ifdef GLITCH_TIMESTAMP_EN
            m_tsc = 0;
`endif
            exp_q.delete();
            check("rst_tdl_in", tdl_in, 0);
            check("rst_valid", event_valid, 0);
            check("rst_count", event_count, 0);
            check("rst_ts", event_ts, 0);
            check("rst_flag", glitch_flag, 0);
            check("rst_overflow", overflow, 0);
            check("rst_armed", armed, 0);
        end else begin
            check("tdl_in", tdl_in, (k_en > 0) ? (k_en % 2) : 0);
            check("armed", armed, (k_en > int'(WARMUP)) ? 1 : 0);
            check("event_valid", event_valid, m_valid);
            check("event_count", event_count, m_count);
            check("glitch_flag", glitch_flag, m_flag);
            check("overflow", overflow, m_ovf);

            mism   = corrupt_prev && (k_en > int'(WARMUP));
            run    = mism ? ((run < 255) ? run + 1 : 255) : 0;
            fire_m = mism && (run == int'(THRESH));
            acc    = m_valid && event_ready;
            if (clear) begin
                m_count = 0; m_flag = 0; m_ovf = 0;
            end
            if (acc) m_valid = 0;
            if (fire_m) begin
                if (m_count < (1 << CW) - 1) m_count++;
                m_flag = 1;
                if (!m_valid) begin
                    m_valid = 1;
`ifdef GLITCH_TIMESTAMP_EN
                    exp_q.push_back(CW'(m_tsc));
`else
                    exp_q.push_back('0);
`endif
                end else begin
                    m_ovf = 1;
                end
            end
            k_en = enable ? k_en + 1 : 0;
            corrupt_prev = corrupt;
`ifdef GLITCH_TIMESTAMP_EN
            m_tsc = (m_tsc + 1) % (1 << CW);
`endif
        end
    end

    // Scoreboard monitor: every transfer must match the oldest expected record.
    always @(negedge clk_ps) begin
        if (resetn && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got ts %0h expected no record at %0t",
                         event_ts, $time);
            end else begin
                check("event_ts", event_ts, exp_q.pop_front());
            end
        end
    end

    int burst = 0;
    int dis_left = 0;

    initial begin
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;

        // Clean run
        enable = 1'b1;
        event_ready = 1'b1;
        repeat (16) tick();
        check("armed_cycle16", armed, 0);
        tick();
        check("armed_cycle17", armed, 1);
        repeat (300) tick();
        check("clean_count", event_count, 0);
        check("clean_flag", glitch_flag, 0);

        // Single glitches of varying length
        glitch(1);
        check("one_mismatch_count", event_count, 0);
        glitch(2);
        check("two_mismatch_count", event_count, 1);
        glitch(3);
        check("three_mismatch_count", event_count, 2);
        glitch(1);
        check("one_more_mismatch_count", event_count, 2);

        // Warmup masking
        enable = 1'b0;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        corrupt = 1'b1;
        repeat (16) tick();
        corrupt = 1'b0;
        repeat (10) tick();
        check("warmup_count", event_count, 0);
        check("warmup_flag", glitch_flag, 0);

        // Backpressure
        event_ready = 1'b0;
        repeat (3) glitch(2);
        check("bp_count", event_count, 3);
        check("bp_overflow", overflow, 1);
        check("bp_valid", event_valid, 1);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        check("bp_drained", event_valid, 0);

        // Fire together with accept refills the slot
        glitch(2);
        corrupt = 1'b1;
        repeat (2) tick();
        corrupt = 1'b0;
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        check("refill_valid", event_valid, 1);
        check("refill_count", event_count, 5);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        repeat (4) tick();

        // Fire together with clear
        corrupt = 1'b1;
        repeat (2) tick();
        corrupt = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_fire_count", event_count, 1);
        check("clear_fire_flag", glitch_flag, 1);
        check("clear_fire_overflow", overflow, 0);
        event_ready = 1'b1;
        repeat (4) tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (dis_left > 0) begin
                enable = 1'b0;
                dis_left--;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 299) == 0) dis_left = $urandom_range(1, 5);
            end
            if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 4);
            corrupt = (burst > 0);
            if (burst > 0) burst--;
            event_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 63) == 0);
            tick();
        end
        corrupt = 1'b0;
        clear = 1'b0;

        // Asynchronous reset with an event pending
        enable = 1'b1;
        event_ready = 1'b1;
        repeat (2) tick();
        event_ready = 1'b0;
        repeat (20) tick();
        glitch(2);
        check("pre_reset_valid", event_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", event_valid, 0);
        check("async_rst_count", event_count, 0);
        check("async_rst_flag", glitch_flag, 0);
        check("async_rst_armed", armed, 0);
        check("async_rst_tdl", tdl_in, 0);
        repeat (2) tick();
        resetn = 1'b1;

        // Disable returns to IDLE with launch low
        repeat (25) tick();
        enable = 1'b0;
        tick();
        check("disable_tdl", tdl_in, 0);
        check("disable_armed", armed, 0);

        event_ready = 1'b1;
        repeat (5) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
